// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared types and constants for the blink-count player.
//   state_t         : playback FSM states
//   HUND/TENS/UNITS : digit_sel encodings
//   DEF_*_CYCLES    : default blink timing in 50 MHz clock cycles
//   add3()          : double-dabble digit correction step
// -----------------------------------------------------------------------------
package blink_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    ON      = 3'd2,
    OFF     = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] HUND  = 2'd2;
  localparam logic [1:0] TENS  = 2'd1;
  localparam logic [1:0] UNITS = 2'd0;

  localparam int DEF_ON_CYCLES   = 12500000;
  localparam int DEF_OFF_CYCLES  = 12500000;
  localparam int DEF_GAP_CYCLES  = 50000000;
  localparam int DEF_ZERO_CYCLES = 37500000;

  // A BCD digit of 5 or more would overflow after the next left shift,
  // so it is pre-corrected by adding 3.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// valid pulses for one cycle exactly 8 cycles after the start cycle; the
// digit outputs then hold until the next start.
//   clk   in   clock
//   srst  in   synchronous active-high reset
//   start in   load bin and begin conversion
//   bin   in   8-bit binary input, sampled with start
//   valid out  one-cycle pulse, digits are ready
//   hund  out  hundreds digit
//   tens  out  tens digit
//   units out  units digit
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import blink_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       valid,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] units
);

  // {hund, tens, units, remaining binary bits}
  logic [19:0] shift_reg;
  logic [19:0] adj;
  logic [2:0]  iter_reg;
  logic        active_reg;
  logic        valid_reg;

  assign adj[7:0] = shift_reg[7:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[8 + 4*gi +: 4] = add3(shift_reg[8 + 4*gi +: 4]);
    end
  endgenerate

  // The load cycle already performs the first shift (the BCD field is zero
  // then, so no correction is needed); seven more iterations follow.
  always_ff @(posedge clk) begin
    if (srst) begin
      shift_reg  <= '0;
      iter_reg   <= '0;
      active_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (start) begin
        shift_reg  <= {11'd0, bin, 1'b0};
        iter_reg   <= 3'd7;
        active_reg <= 1'b1;
      end else if (active_reg) begin
        shift_reg <= {adj[18:0], 1'b0};
        iter_reg  <= iter_reg - 3'd1;
        if (iter_reg == 3'd1) begin
          active_reg <= 1'b0;
          valid_reg  <= 1'b1;
        end
      end
    end
  end

  assign valid = valid_reg;
  assign hund  = shift_reg[19:16];
  assign tens  = shift_reg[15:12];
  assign units = shift_reg[11:8];

endmodule

// File: rtl/blink_count_player.sv
// -----------------------------------------------------------------------------
// blink_count_player
// Replays an 8-bit value on one LED as bursts of blinks, one burst per
// decimal digit, most significant non-zero digit first. Digit d (1..9) is d
// short blinks; digit 0 is one long blink.
//   CLOCK_50  in   clock
//   RESET     in   synchronous active-high reset
//   start     in   play request, accepted only in IDLE
//   value     in   value to play, sampled on acceptance
//   abort     in   cancel playback while busy (no done)
//   blink     out  LED drive
//   busy      out  playback in progress
//   done      out  one-cycle pulse on normal completion
//   digit     out  BCD digit being played (0 when idle)
//   digit_sel out  2=hundreds, 1=tens, 0=units (0 when idle)
// -----------------------------------------------------------------------------
module blink_count_player
  import blink_pkg::*;
#(
  parameter int ON_CYCLES   = DEF_ON_CYCLES,
  parameter int OFF_CYCLES  = DEF_OFF_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ZERO_CYCLES = DEF_ZERO_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       abort,
  output logic       blink,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit,
  output logic [1:0] digit_sel
);

  localparam int MAX_A = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_B = (GAP_CYCLES > ZERO_CYCLES) ? GAP_CYCLES : ZERO_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // The counter is loaded with duration-1, so it never exceeds MAX_C-1.
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [TW-1:0] ON_LOAD   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD  = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ZERO_LOAD = TW'(ZERO_CYCLES - 1);

  state_t          state_reg,  state_next;
  logic [TW-1:0]   tcnt_reg,   tcnt_next;
  logic [3:0]      blinks_reg, blinks_next;
  logic [3:0]      digit_reg,  digit_next;
  logic [1:0]      sel_reg,    sel_next;

  logic            bcd_start;
  logic            bcd_valid;
  logic [3:0]      bcd_hund, bcd_tens, bcd_units;

  logic            load_digit;
  logic [3:0]      enter_digit;
  logic [1:0]      enter_sel;
  logic            tick_done;

  assign bcd_start = start && (state_reg == IDLE);

  bin2bcd_seq u_bcd (
    .clk   (CLOCK_50),
    .srst  (RESET),
    .start (bcd_start),
    .bin   (value),
    .valid (bcd_valid),
    .hund  (bcd_hund),
    .tens  (bcd_tens),
    .units (bcd_units)
  );

  assign blink = (state_reg == ON);
  assign busy  = (state_reg == CONVERT) || (state_reg == ON) ||
                 (state_reg == OFF)     || (state_reg == GAP);
  assign done  = (state_reg == DONE);
  assign digit     = digit_reg;
  assign digit_sel = sel_reg;

  assign tick_done = (tcnt_reg == '0);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg  <= IDLE;
      tcnt_reg   <= '0;
      blinks_reg <= '0;
      digit_reg  <= '0;
      sel_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      tcnt_reg   <= tcnt_next;
      blinks_reg <= blinks_next;
      digit_reg  <= digit_next;
      sel_reg    <= sel_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    tcnt_next   = tcnt_reg;
    blinks_next = blinks_reg;
    digit_next  = digit_reg;
    sel_next    = sel_reg;
    load_digit  = 1'b0;

    // First digit to play: leading zeros suppressed, units always played.
    if (bcd_hund != 4'd0) begin
      enter_sel   = HUND;
      enter_digit = bcd_hund;
    end else if (bcd_tens != 4'd0) begin
      enter_sel   = TENS;
      enter_digit = bcd_tens;
    end else begin
      enter_sel   = UNITS;
      enter_digit = bcd_units;
    end

    case (state_reg)
      IDLE: begin
        if (start) state_next = CONVERT;
      end
      CONVERT: begin
        if (bcd_valid) load_digit = 1'b1;
      end
      ON: begin
        if (tick_done) begin
          // GAP replaces the OFF after the last blink of a non-final digit.
          if ((blinks_reg == 4'd1) && (sel_reg != UNITS)) begin
            state_next = GAP;
            tcnt_next  = GAP_LOAD;
          end else begin
            state_next = OFF;
            tcnt_next  = OFF_LOAD;
          end
        end else begin
          tcnt_next = tcnt_reg - 1'b1;
        end
      end
      OFF: begin
        if (tick_done) begin
          if (blinks_reg == 4'd1) begin
            state_next = DONE;
            digit_next = '0;
            sel_next   = '0;
          end else begin
            // More than one blink implies a non-zero digit: short blink.
            state_next  = ON;
            blinks_next = blinks_reg - 4'd1;
            tcnt_next   = ON_LOAD;
          end
        end else begin
          tcnt_next = tcnt_reg - 1'b1;
        end
      end
      GAP: begin
        if (tick_done) begin
          load_digit  = 1'b1;
          enter_sel   = sel_reg - 2'd1;
          enter_digit = (sel_reg == HUND) ? bcd_tens : bcd_units;
        end else begin
          tcnt_next = tcnt_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (load_digit) begin
      state_next  = ON;
      digit_next  = enter_digit;
      sel_next    = enter_sel;
      blinks_next = (enter_digit == 4'd0) ? 4'd1 : enter_digit;
      tcnt_next   = (enter_digit == 4'd0) ? ZERO_LOAD : ON_LOAD;
    end

    if (abort && busy) begin
      state_next  = IDLE;
      tcnt_next   = '0;
      blinks_next = '0;
      digit_next  = '0;
      sel_next    = '0;
    end
  end

endmodule

// File: tb/tb_blink_count_player.sv
// -----------------------------------------------------------------------------
// tb_blink_count_player
// Directed bench for blink_count_player with short timing (ON=2, OFF=3,
// GAP=5, ZERO=4). Cycle 0 is the cycle in which start is presented; outputs
// of cycle k are sampled on the falling edge inside that cycle.
// -----------------------------------------------------------------------------
module tb_blink_count_player;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] value;
  logic       abort;
  logic       blink;
  logic       busy;
  logic       done;
  logic [3:0] digit;
  logic [1:0] digit_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  blink_count_player #(
    .ON_CYCLES   (2),
    .OFF_CYCLES  (3),
    .GAP_CYCLES  (5),
    .ZERO_CYCLES (4)
  ) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .start     (start),
    .value     (value),
    .abort     (abort),
    .blink     (blink),
    .busy      (busy),
    .done      (done),
    .digit     (digit),
    .digit_sel (digit_sel)
  );

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; value = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({blink, busy, done, digit, digit_sel} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {blink, busy, done, digit, digit_sel});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({blink, busy, done, digit, digit_sel} !== 9'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %b expected 0", {blink, busy, done, digit, digit_sel});
    end
    $display("test_reset done");
  endtask

  task automatic test_value3();
    logic [127:0] on_m, busy_m, done_m;
    on_m = rng(9, 10) | rng(14, 15) | rng(19, 20);
    busy_m = rng(1, 23); done_m = rng(24, 24);
    @(negedge clk); start = 1'b1; value = 8'd3;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk); start = 1'b0;
      n_checks++;
      if ({blink, busy, done} !== {on_m[k], busy_m[k], done_m[k]}) begin
        n_fail++;
        $display("FAIL v3_bbd cycle %0d: got %b expected %b", k, {blink, busy, done}, {on_m[k], busy_m[k], done_m[k]});
      end
      if (k == 9) begin
        n_checks++;
        if (digit !== 4'd3 || digit_sel !== 2'd0) begin
          n_fail++;
          $display("FAIL v3_digit: got %0d/%0d expected 3/0", digit, digit_sel);
        end
      end
    end
    $display("test_value3 done");
  endtask

  task automatic test_value0();
    logic [127:0] on_m, busy_m, done_m;
    on_m = rng(9, 12); busy_m = rng(1, 15); done_m = rng(16, 16);
    @(negedge clk); start = 1'b1; value = 8'd0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk); start = 1'b0;
      n_checks++;
      if ({blink, busy, done} !== {on_m[k], busy_m[k], done_m[k]}) begin
        n_fail++;
        $display("FAIL v0_bbd cycle %0d: got %b expected %b", k, {blink, busy, done}, {on_m[k], busy_m[k], done_m[k]});
      end
      if (k == 10) begin
        n_checks++;
        if (digit !== 4'd0 || digit_sel !== 2'd0) begin
          n_fail++;
          $display("FAIL v0_digit: got %0d/%0d expected 0/0", digit, digit_sel);
        end
      end
    end
    $display("test_value0 done");
  endtask

  task automatic test_value102();
    logic [127:0] on_m, busy_m, done_m;
    on_m = rng(9, 10) | rng(16, 19) | rng(25, 26) | rng(30, 31);
    busy_m = rng(1, 34); done_m = rng(35, 35);
    @(negedge clk); start = 1'b1; value = 8'd102;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk); start = 1'b0;
      n_checks++;
      if ({blink, busy, done} !== {on_m[k], busy_m[k], done_m[k]}) begin
        n_fail++;
        $display("FAIL v102_bbd cycle %0d: got %b expected %b", k, {blink, busy, done}, {on_m[k], busy_m[k], done_m[k]});
      end
      if (k == 9 || k == 15 || k == 16 || k == 25) begin
        logic [5:0] exp_ds;
        exp_ds = (k == 9 || k == 15) ? {4'd1, 2'd2} : (k == 16) ? {4'd0, 2'd1} : {4'd2, 2'd0};
        n_checks++;
        if ({digit, digit_sel} !== exp_ds) begin
          n_fail++;
          $display("FAIL v102_digit cycle %0d: got %0d/%0d expected %0d/%0d", k, digit, digit_sel, exp_ds[5:2], exp_ds[1:0]);
        end
      end
    end
    $display("test_value102 done");
  endtask

  task automatic test_value255();
    logic [127:0] on_m, busy_m, done_m;
    int rises, dones;
    logic prev;
    on_m = rng(9, 10) | rng(14, 15) | rng(21, 22) | rng(26, 27) | rng(31, 32) |
           rng(36, 37) | rng(41, 42) | rng(48, 49) | rng(53, 54) | rng(58, 59) |
           rng(63, 64) | rng(68, 69);
    busy_m = rng(1, 72); done_m = rng(73, 73);
    rises = 0; dones = 0; prev = 1'b0;
    @(negedge clk); start = 1'b1; value = 8'd255;
    for (int k = 1; k <= 76; k++) begin
      @(negedge clk); start = 1'b0;
      if (blink && !prev) rises++;
      prev = blink;
      if (done) dones++;
      n_checks++;
      if ({blink, busy, done} !== {on_m[k], busy_m[k], done_m[k]}) begin
        n_fail++;
        $display("FAIL v255_bbd cycle %0d: got %b expected %b", k, {blink, busy, done}, {on_m[k], busy_m[k], done_m[k]});
      end
      if (k == 9 || k == 21 || k == 48) begin
        logic [5:0] exp_ds;
        exp_ds = (k == 9) ? {4'd2, 2'd2} : (k == 21) ? {4'd5, 2'd1} : {4'd5, 2'd0};
        n_checks++;
        if ({digit, digit_sel} !== exp_ds) begin
          n_fail++;
          $display("FAIL v255_digit cycle %0d: got %0d/%0d expected %0d/%0d", k, digit, digit_sel, exp_ds[5:2], exp_ds[1:0]);
        end
      end
    end
    n_checks++;
    if (rises !== 12 || dones !== 1) begin
      n_fail++;
      $display("FAIL v255_counts: got %0d blinks %0d dones expected 12 blinks 1 done", rises, dones);
    end
    $display("test_value255 done");
  endtask

  task automatic test_start_ignored();
    logic [127:0] on_m, busy_m, done_m;
    on_m = rng(9, 10) | rng(16, 19); busy_m = rng(1, 22); done_m = rng(23, 23);
    @(negedge clk); start = 1'b1; value = 8'd10;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({blink, busy, done} !== {on_m[k], busy_m[k], done_m[k]}) begin
        n_fail++;
        $display("FAIL v10_bbd cycle %0d: got %b expected %b", k, {blink, busy, done}, {on_m[k], busy_m[k], done_m[k]});
      end
      if (k == 5) begin
        start = 1'b1; value = 8'd99;
      end
      if (k == 9 || k == 15 || k == 16) begin
        logic [5:0] exp_ds;
        exp_ds = (k == 16) ? {4'd0, 2'd0} : {4'd1, 2'd1};
        n_checks++;
        if ({digit, digit_sel} !== exp_ds) begin
          n_fail++;
          $display("FAIL v10_digit cycle %0d: got %0d/%0d expected %0d/%0d", k, digit, digit_sel, exp_ds[5:2], exp_ds[1:0]);
        end
      end
    end
    $display("test_start_ignored done");
  endtask

  // use_reset=0 cancels with abort, use_reset=1 with RESET.
  task automatic test_cancel(input bit use_reset);
    @(negedge clk); start = 1'b1; value = 8'd255;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); start = 1'b0;
    end
    n_checks++;
    if ({blink, busy, digit, digit_sel} !== {1'b1, 1'b1, 4'd2, 2'd2}) begin
      n_fail++;
      $display("FAIL cancel_pre rst=%0d: got %b expected 11001010", use_reset, {blink, busy, digit, digit_sel});
    end
    if (use_reset) rst = 1'b1; else abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; abort = 1'b0;
    n_checks++;
    if ({blink, busy, done, digit, digit_sel} !== 9'd0) begin
      n_fail++;
      $display("FAIL cancel_post rst=%0d: got %b expected 0", use_reset, {blink, busy, done, digit, digit_sel});
    end
    for (int k = 12; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cancel_idle rst=%0d cycle %0d: got done=%b busy=%b expected 0 0", use_reset, k, done, busy);
      end
    end
    $display("test_cancel rst=%0d done", use_reset);
  endtask

  task automatic test_restart();
    logic [127:0] on_m, busy_m, done_m;
    on_m = rng(9, 10); busy_m = rng(1, 13); done_m = rng(14, 14);
    @(negedge clk); start = 1'b1; value = 8'd1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); start = 1'b0;
      n_checks++;
      if ({blink, busy, done} !== {on_m[k], busy_m[k], done_m[k]}) begin
        n_fail++;
        $display("FAIL v1_bbd cycle %0d: got %b expected %b", k, {blink, busy, done}, {on_m[k], busy_m[k], done_m[k]});
      end
    end
    $display("test_restart done");
  endtask

  initial begin
    test_reset();
    test_value3();
    test_value0();
    test_value102();
    test_value255();
    test_start_ignored();
    test_cancel(1'b0);
    test_cancel(1'b1);
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
